// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 receiver: synchronizes the raw pins, frames bytes with a watchdog,
// and tracks the held key, press flag and press count. Optional macro: PS2_PARITY_CHECK_EN.
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       is_press,
    output logic [7:0] count,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t      state, state_nxt;
    logic        clk_s1, clk_s2, clk_s3;
    logic        data_s1, data_s2;
    logic        fall;
    logic [2:0]  bitcnt, bitcnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        par_bit, par_nxt;
    logic        parity_ok;
    logic [WD_W-1:0] wd;
    logic        expire;
    logic        frame_ok, frame_bad;
    logic        brk_pend;

    // Sync flops reset to the idle-high line level so reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fall = clk_s3 & ~clk_s2;

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^{shreg, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    // wd holds (cycles since the last fall) - 1, so expiry lands TIMEOUT_CYCLES after it.
    assign expire = (state != IDLE) && !fall && (wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        par_nxt    = par_bit;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_s2) begin
                        state_nxt  = DATA;
                        bitcnt_nxt = 3'd0;
                    end
                end
                DATA: begin
                    shreg_nxt  = {data_s2, shreg[7:1]};
                    bitcnt_nxt = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    par_nxt   = data_s2;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (data_s2 && parity_ok) frame_ok = 1'b1;
                    else                      frame_bad = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (expire) begin
            state_nxt = IDLE;
            frame_bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bitcnt  <= 3'd0;
            shreg   <= 8'h00;
            par_bit <= 1'b0;
        end else begin
            state   <= state_nxt;
            bitcnt  <= bitcnt_nxt;
            shreg   <= shreg_nxt;
            par_bit <= par_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || fall || state_nxt == IDLE) wd <= '0;
        else                                  wd <= wd + WD_W'(1);
    end

    // Make/break decode; shreg already holds the complete byte while in STOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            key        <= 8'h00;
            is_press   <= 1'b0;
            count      <= 8'h00;
            brk_pend   <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= frame_ok;
            frame_err  <= frame_bad;
            if (frame_ok) begin
                if (shreg == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else if (brk_pend) begin
                    brk_pend <= 1'b0;
                    if (is_press && shreg == key) is_press <= 1'b0;
                end else if (!(is_press && shreg == key)) begin
                    key      <= shreg;
                    is_press <= 1'b1;
                    count    <= count + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: table of frames with expected results, plus watchdog,
// mid-frame reset and count-wrap sequences; results are checked through an expected queue.
module tb_ps2_key_tracker;
    localparam int T    = 100;
    localparam int HALF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key;
    logic       is_press;
    logic [7:0] count;
    logic       byte_valid;
    logic       frame_err;

    ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key        (key),
        .is_press   (is_press),
        .count      (count),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        logic [7:0] key;
        bit         pr;
        logic [7:0] cnt;
        bit         acc;
    } vec_t;

    vec_t        vecs[10];
    logic [16:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          stop_cyc = 0;
    int          err_cnt = 0;
    int          exp_err = 0;
    int          c9;
    int          got;
    logic [7:0]  m_key;
    bit          m_pr;
    logic [7:0]  m_cnt;
    bit          m_brk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // scoreboard: pop one expected {key,is_press,count} per byte_valid pulse
    always @(negedge clk) begin : monitor
        logic [16:0] e;
        if (frame_err) err_cnt++;
        if (byte_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("key", {24'd0, key}, {24'd0, e[16:9]});
                check("is_press", {31'd0, is_press}, {31'd0, e[8]});
                check("count", {24'd0, count}, {24'd0, e[7:0]});
            end
            check("byte_latency", cyc - stop_cyc, 32'd3);
        end
    end

    // driver tasks
    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            if (i == 10) stop_cyc = cyc;
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // start bit plus n_data bits of 0xA5; ps2_clk is left low after the last bit
    task automatic send_partial(input int n_data);
        logic [8:0] bits;
        bits = {8'hA5, 1'b0};
        for (int i = 0; i <= n_data; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i < n_data) begin
                repeat (HALF) @(negedge clk);
                ps2_clk = 1'b1;
            end
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            m_brk = 1'b0;
            if (m_pr && b == m_key) m_pr = 1'b0;
        end else if (!(m_pr && b == m_key)) begin
            m_key = b;
            m_pr  = 1'b1;
            m_cnt = m_cnt + 8'd1;
        end
        exp_q.push_back({m_key, m_pr, m_cnt});
    endtask

    task automatic model_frame(input logic [7:0] b);
        model_push(b);
        send_frame(b, 1'b0);
    endtask

    initial begin : watchdog_global
        repeat (150000) @(posedge clk);
        $display("FAIL global_timeout: got no finish, expected finish within 150000 cycles");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stimulus
        vecs[0] = '{8'h1C, 1'b0, 8'h1C, 1'b1, 8'h01, 1'b1};
        vecs[1] = '{8'h1C, 1'b0, 8'h1C, 1'b1, 8'h01, 1'b1};
        vecs[2] = '{8'h1C, 1'b0, 8'h1C, 1'b1, 8'h01, 1'b1};
        vecs[3] = '{8'h1C, 1'b0, 8'h1C, 1'b1, 8'h01, 1'b1};
        vecs[4] = '{8'hF0, 1'b0, 8'h1C, 1'b1, 8'h01, 1'b1};
        vecs[5] = '{8'h32, 1'b0, 8'h1C, 1'b1, 8'h01, 1'b1};
        vecs[6] = '{8'hF0, 1'b0, 8'h1C, 1'b1, 8'h01, 1'b1};
        vecs[7] = '{8'h1C, 1'b0, 8'h1C, 1'b0, 8'h01, 1'b1};
`ifdef PS2_PARITY_CHECK_EN
        vecs[8] = '{8'h1C, 1'b1, 8'h1C, 1'b0, 8'h01, 1'b0};
        c9 = 1;
`else
        vecs[8] = '{8'h1C, 1'b1, 8'h1C, 1'b1, 8'h02, 1'b1};
        c9 = 2;
`endif
        vecs[9] = '{8'h5A, 1'b0, 8'h5A, 1'b1, 8'(c9 + 1), 1'b1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_key", {24'd0, key}, 32'h00);
        check("rst_is_press", {31'd0, is_press}, 32'd0);
        check("rst_count", {24'd0, count}, 32'h00);
        check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].acc) exp_q.push_back({vecs[i].key, vecs[i].pr, vecs[i].cnt});
            else             exp_err++;
            send_frame(vecs[i].code, vecs[i].bad_par);
            check("table_pending", exp_q.size(), 32'd0);
        end
        check("table_frame_err_count", err_cnt, exp_err);

        m_key = 8'h5A;
        m_pr  = 1'b1;
        m_cnt = 8'(c9 + 1);
        m_brk = 1'b0;

        // partial frame, then ps2_clk parked high until the watchdog fires
        send_partial(5);
        got = -1;
        for (int i = 1; i <= T + 20; i++) begin
            @(negedge clk);
            if (i == HALF) ps2_clk = 1'b1;
            if (frame_err && got < 0) got = i;
        end
        ps2_data = 1'b1;
        exp_err++;
        check("watchdog_latency", got, T + 3);
        check("watchdog_frame_err_count", err_cnt, exp_err);
        check("watchdog_no_byte", exp_q.size(), 32'd0);
        model_frame(8'h23);
        check("after_timeout_pending", exp_q.size(), 32'd0);
        check("after_timeout_key", {24'd0, key}, 32'h23);

        // reset in the middle of a frame
        send_partial(3);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_key", {24'd0, key}, 32'h00);
        check("midrst_is_press", {31'd0, is_press}, 32'd0);
        check("midrst_count", {24'd0, count}, 32'h00);
        check("midrst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        m_key = 8'h00;
        m_pr  = 1'b0;
        m_cnt = 8'h00;
        m_brk = 1'b0;
        repeat (2) @(negedge clk);

        // 256 press/release pairs: count must come back around to zero
        for (int p = 0; p < 256; p++) begin
            logic [7:0] b;
            b = p[0] ? 8'h32 : 8'h1C;
            model_frame(b);
            model_frame(8'hF0);
            model_frame(b);
        end
        check("wrap_pending", exp_q.size(), 32'd0);
        check("wrap_count", {24'd0, count}, 32'h00);
        check("wrap_is_press", {31'd0, is_press}, 32'd0);
        check("final_frame_err_count", err_cnt, exp_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
